// File: rtl/kpt_pkg.sv
// rtl/kpt_pkg.sv - shared keypoint widths, record type and reader state encoding
package kpt_pkg;

  localparam int COOR_W  = 10;
  localparam int SCORE_W = 8;
  localparam int DESC_W  = 256;

  // One keypoint as presented at the buffer head and held for the matcher
  typedef struct packed {
    logic [COOR_W-1:0]  coor_x;
    logic [COOR_W-1:0]  coor_y;
    logic [SCORE_W-1:0] score;
    logic [DESC_W-1:0]  descriptor;
  } kpt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SEND,
    ST_POP,
    ST_DONE
  } reader_state_t;

endpackage

// File: rtl/key_buffer_reader_if.sv
// rtl/key_buffer_reader_if.sv - keypoint stream from the reader to the descriptor matcher
interface key_buffer_reader_if;
  import kpt_pkg::*;

  logic               valid;
  logic               ready;
  logic [COOR_W-1:0]  coor_x;
  logic [COOR_W-1:0]  coor_y;
  logic [SCORE_W-1:0] score;
  logic [DESC_W-1:0]  descriptor;

  modport master (
    output valid,
    output coor_x,
    output coor_y,
    output score,
    output descriptor,
    input  ready
  );

  modport slave (
    input  valid,
    input  coor_x,
    input  coor_y,
    input  score,
    input  descriptor,
    output ready
  );

endinterface

// File: rtl/key_buffer_reader.sv
// rtl/key_buffer_reader.sv - drains the keypoint buffer to the matcher; KEY_READER_MINSCORE_EN selects min-score filtering
module key_buffer_reader
  import kpt_pkg::*;
#(
  parameter int                 DEPTH     = 100,
  parameter logic [SCORE_W-1:0] MIN_SCORE = 8'd1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_buf_wr,
  input  logic [COOR_W-1:0]   i_coor_x,
  input  logic [COOR_W-1:0]   i_coor_y,
  input  logic [SCORE_W-1:0]  i_score,
  input  logic [DESC_W-1:0]   i_descriptor,
  output logic                o_next,
  key_buffer_reader_if.master m_kpt,
  output logic                o_busy,
  output logic                o_done,
  output logic [9:0]          o_num_kpt
);

  localparam int                SLOT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DEPTH - 1);
  localparam logic [9:0]        KPT_MAX   = 10'(DEPTH);

  reader_state_t     state_q;
  kpt_t              kpt_q;
  logic [SLOT_W-1:0] slot_q;
  logic [9:0]        kpt_cnt_q;
  logic [9:0]        num_kpt_q;
  logic              score_pass;

`ifdef KEY_READER_MINSCORE_EN
  assign score_pass = (i_score >= MIN_SCORE);
`else
  // Empty slots carry score 0; the threshold only matters in the filtered build
  assign score_pass = (i_score != '0);
  wire [SCORE_W-1:0] unused_min_score = MIN_SCORE;
`endif

  // Pop is withheld while the buffer is inserting so the two never collide
  assign o_next       = (state_q == ST_POP) && !i_buf_wr;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  assign o_num_kpt    = num_kpt_q;

  assign m_kpt.valid      = (state_q == ST_SEND);
  assign m_kpt.coor_x     = kpt_q.coor_x;
  assign m_kpt.coor_y     = kpt_q.coor_y;
  assign m_kpt.score      = kpt_q.score;
  assign m_kpt.descriptor = kpt_q.descriptor;

  // Drain sequencer: capture head, optionally send, pop, repeat DEPTH times
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      kpt_q     <= '0;
      slot_q    <= '0;
      kpt_cnt_q <= '0;
      num_kpt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q   <= ST_CAPTURE;
            slot_q    <= '0;
            kpt_cnt_q <= '0;
          end
        end
        ST_CAPTURE: begin
          kpt_q.coor_x     <= i_coor_x;
          kpt_q.coor_y     <= i_coor_y;
          kpt_q.score      <= i_score;
          kpt_q.descriptor <= i_descriptor;
          state_q          <= score_pass ? ST_SEND : ST_POP;
        end
        ST_SEND: begin
          if (m_kpt.ready) begin
            if (kpt_cnt_q != KPT_MAX) begin
              kpt_cnt_q <= kpt_cnt_q + 10'd1;
            end
            state_q <= ST_POP;
          end
        end
        ST_POP: begin
          if (!i_buf_wr) begin
            // The head advances on this edge, so CAPTURE next cycle sees the new slot
            if (slot_q == SLOT_LAST) begin
              state_q <= ST_DONE;
            end else begin
              slot_q  <= slot_q + SLOT_W'(1);
              state_q <= ST_CAPTURE;
            end
          end
        end
        ST_DONE: begin
          num_kpt_q <= kpt_cnt_q;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_buffer_reader.sv
// tb/tb_key_buffer_reader.sv - directed self-checking bench for key_buffer_reader
module tb_key_buffer_reader;
  import kpt_pkg::*;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         buf_wr;
  logic         rdy;
  logic [9:0]   coor_x;
  logic [9:0]   coor_y;
  logic [7:0]   score;
  logic [255:0] desc;
  logic         nxt;
  logic         busy;
  logic         done;
  logic [9:0]   num_kpt;

  key_buffer_reader_if kpt_if();
  assign kpt_if.ready = rdy;

  key_buffer_reader #(.DEPTH(DEPTH), .MIN_SCORE(8'd6)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_buf_wr     (buf_wr),
    .i_coor_x     (coor_x),
    .i_coor_y     (coor_y),
    .i_score      (score),
    .i_descriptor (desc),
    .o_next       (nxt),
    .m_kpt        (kpt_if),
    .o_busy       (busy),
    .o_done       (done),
    .o_num_kpt    (num_kpt)
  );

  always #5 clk = ~clk;

  // Buffer model: four slots, head advances on each pop, never re-synced by DUT reset
  logic [7:0] tbl [4];
  logic [1:0] head;
  logic       buf_clr;

  always @(posedge clk) begin
    if (buf_clr) head <= 2'd0;
    else if (nxt) head <= head + 2'd1;
  end

  assign score  = tbl[head];
  assign coor_x = 10'd200 + {2'b00, tbl[head]};
  assign coor_y = {8'b0, head};
  assign desc   = {32{tbl[head]}};

  // Monitor: pops, done pulses and accepted keypoints
  int         pop_cnt  = 0;
  int         done_cnt = 0;
  logic [7:0] sent_score [$];
  logic [9:0] sent_x [$];

  always @(negedge clk) begin
    if (nxt) pop_cnt++;
    if (done) done_cnt++;
    if (kpt_if.valid && kpt_if.ready) begin
      sent_score.push_back(kpt_if.score);
      sent_x.push_back(kpt_if.coor_x);
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_buf();
    buf_clr = 1'b1;
    tick();
    buf_clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
    tbl[0] = s0;
    tbl[1] = s1;
    tbl[2] = s2;
    tbl[3] = s3;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int n;
    n = 0;
    while (done_cnt == base && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (done_cnt == base) check_eq({tag, "_timeout"}, 256'd0, 256'd1);
    tick();
  endtask

  int pb, db, sb, n;
  logic [7:0] exp_s [3];
  int exp_n;

  initial begin
    load(8'd0, 8'd0, 8'd0, 8'd0);
    rst = 1'b1; start = 1'b0; buf_wr = 1'b0; rdy = 1'b0; buf_clr = 1'b1;
    repeat (3) tick();
    rst = 1'b0; buf_clr = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", kpt_if.valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_next", nxt, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_num", num_kpt, 10'd0);
    check_eq("rst_x", kpt_if.coor_x, 10'd0);
    tick();

    // 1: basic drain with ready high, plus start-to-valid latency
    load(8'd5, 8'd0, 8'd9, 8'd0); rdy = 1'b1; clr_buf();
    pb = pop_cnt; db = done_cnt; sb = sent_score.size();
    pulse_start();
    check_eq("t1_valid_e1", kpt_if.valid, 1'b0);
    check_eq("t1_busy_e1", busy, 1'b1);
    tick();
    check_eq("t1_valid_e2", kpt_if.valid, 1'b1);
    check_eq("t1_score_e2", kpt_if.score, 8'd5);
    wait_done(db, "t1");
    repeat (3) tick();
    check_eq("t1_pops", pop_cnt - pb, 4);
    check_eq("t1_dones", done_cnt - db, 1);
    check_eq("t1_num", num_kpt, 10'd2);
    check_eq("t1_nsent", sent_score.size() - sb, 2);
    if (sent_score.size() - sb == 2) begin
      check_eq("t1_s0", sent_score[sb], 8'd5);
      check_eq("t1_s1", sent_score[sb+1], 8'd9);
      check_eq("t1_x1", sent_x[sb+1], 10'd209);
    end
    check_eq("t1_busy_end", busy, 1'b0);

    // 2: backpressure holds the first keypoint stable
    load(8'd5, 8'd0, 8'd9, 8'd0); rdy = 1'b0; clr_buf();
    pb = pop_cnt; db = done_cnt;
    pulse_start();
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("t2_valid", kpt_if.valid, 1'b1);
      check_eq("t2_x", kpt_if.coor_x, 10'd205);
      check_eq("t2_desc", kpt_if.descriptor, {32{8'd5}});
      check_eq("t2_nopop", pop_cnt - pb, 0);
      tick();
    end
    rdy = 1'b1;
    wait_done(db, "t2");
    check_eq("t2_pops", pop_cnt - pb, 4);
    check_eq("t2_num", num_kpt, 10'd2);

    // 3: buffer writes stall the pop
    load(8'd0, 8'd7, 8'd0, 8'd0); rdy = 1'b1; clr_buf();
    pb = pop_cnt; db = done_cnt;
    pulse_start();
    tick();
    buf_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_stall_next", nxt, 1'b0);
      tick();
    end
    check_eq("t3_stall_pops", pop_cnt - pb, 0);
    buf_wr = 1'b0;
    @(negedge clk);
    check_eq("t3_next_4th", nxt, 1'b1);
    wait_done(db, "t3");
    check_eq("t3_pops", pop_cnt - pb, 4);
    check_eq("t3_num", num_kpt, 10'd1);

    // 4: start while busy is ignored
    load(8'd5, 8'd0, 8'd9, 8'd0); rdy = 1'b1; clr_buf();
    pb = pop_cnt; db = done_cnt;
    pulse_start();
    tick(); tick();
    pulse_start();
    wait_done(db, "t4");
    repeat (6) tick();
    check_eq("t4_pops", pop_cnt - pb, 4);
    check_eq("t4_dones", done_cnt - db, 1);
    check_eq("t4_num", num_kpt, 10'd2);
    check_eq("t4_busy", busy, 1'b0);

    // 5: reset at slot 2, then a new drain continues from the unsynced head
    load(8'd5, 8'd0, 8'd9, 8'd0); rdy = 1'b1; clr_buf();
    pb = pop_cnt;
    pulse_start();
    n = 0;
    while (pop_cnt - pb < 2 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (pop_cnt - pb < 2) check_eq("t5_reach_timeout", 256'd0, 256'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_valid", kpt_if.valid, 1'b0);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_next", nxt, 1'b0);
    check_eq("t5_done", done, 1'b0);
    check_eq("t5_num", num_kpt, 10'd0);
    check_eq("t5_score", kpt_if.score, 8'd0);
    check_eq("t5_desc", kpt_if.descriptor, 256'd0);
    tick();
    pb = pop_cnt; db = done_cnt; sb = sent_score.size();
    pulse_start();
    wait_done(db, "t5");
    check_eq("t5_pops", pop_cnt - pb, 4);
    check_eq("t5_num2", num_kpt, 10'd2);
    check_eq("t5_nsent", sent_score.size() - sb, 2);
    if (sent_score.size() - sb == 2) begin
      check_eq("t5_s0", sent_score[sb], 8'd9);
      check_eq("t5_s1", sent_score[sb+1], 8'd5);
    end

    // 6: score filter
`ifdef KEY_READER_MINSCORE_EN
    exp_n = 2; exp_s[0] = 8'd6; exp_s[1] = 8'd7; exp_s[2] = 8'd0;
`else
    exp_n = 3; exp_s[0] = 8'd5; exp_s[1] = 8'd6; exp_s[2] = 8'd7;
`endif
    load(8'd5, 8'd6, 8'd7, 8'd0); rdy = 1'b1; clr_buf();
    pb = pop_cnt; db = done_cnt; sb = sent_score.size();
    pulse_start();
    wait_done(db, "t6");
    check_eq("t6_pops", pop_cnt - pb, 4);
    check_eq("t6_num", num_kpt, 10'(exp_n));
    check_eq("t6_nsent", sent_score.size() - sb, exp_n);
    if (sent_score.size() - sb == exp_n) begin
      for (int i = 0; i < exp_n; i++) check_eq("t6_score", sent_score[sb+i], exp_s[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
